// File: rtl/timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : timer_bank
//  Purpose  : N_CH-channel programmable down-counting timer bank behind a
//             single memory-mapped window. Each channel has CTRL, PRESET,
//             COUNT and STAT registers, one-shot / auto-reload modes, an
//             interrupt mask and a write-1-to-clear pending flag.
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset
//             addr   - CPU byte address
//             we     - qualified write strobe
//             wdata  - write data
//             rdata  - combinational read data (0 when not hit)
//             hit    - addr falls inside this bank's window
//             irq    - per-channel pending & IM
//  Options  : TIMER_PRESCALE_EN adds an 8-bit per-channel prescaler
//             (PSC in CTRL[15:8]).
//  Revision : 1.0 - initial release
// ============================================================================
module timer_bank #(
    parameter int          N_CH      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            hit,
    output logic [N_CH-1:0] irq
);

    localparam logic [32:0] C_END_ADDR = {1'b0, BASE_ADDR} + 33'(16 * N_CH);
    localparam logic [1:0]  REG_CTRL   = 2'd0;
    localparam logic [1:0]  REG_PRESET = 2'd1;
    localparam logic [1:0]  REG_COUNT  = 2'd2;
    localparam logic [1:0]  MODE_AUTO  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q  [N_CH];
    state_t             state_d  [N_CH];
    logic [1:0]         mode_q   [N_CH];
    logic [1:0]         mode_d   [N_CH];
    logic [CNT_W-1:0]   preset_q [N_CH];
    logic [CNT_W-1:0]   preset_d [N_CH];
    logic [CNT_W-1:0]   count_q  [N_CH];
    logic [CNT_W-1:0]   count_d  [N_CH];
    logic [N_CH-1:0]    en_q, en_d;
    logic [N_CH-1:0]    im_q, im_d;
    logic [N_CH-1:0]    pend_q, pend_d;
`ifdef TIMER_PRESCALE_EN
    logic [7:0]         psc_q    [N_CH];
    logic [7:0]         psc_d    [N_CH];
    logic [7:0]         pcnt_q   [N_CH];
    logic [7:0]         pcnt_d   [N_CH];
`endif

    logic [31:0] w_off;
    logic [2:0]  w_ch;
    logic [1:0]  w_reg;
    logic        w_hit;
    logic        w_wr;
    logic        w_unused;

    // Address decode: channel from the offset, register from addr[3:2].
    assign w_hit = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < C_END_ADDR);
    assign w_off = addr - BASE_ADDR;
    assign w_ch  = w_off[6:4];
    assign w_reg = addr[3:2];
    assign w_wr  = we & w_hit;
    assign hit   = w_hit;
    assign irq   = pend_q & im_q;

    // Bits that carry no meaning for this block.
    assign w_unused = ^{w_off, addr[1:0], wdata};

    // ------------------------------------------------------------------
    // Next-state logic for all channels
    // ------------------------------------------------------------------
    always_comb begin
        logic sel_ch, ctrl_wr, preset_wr, stat_clr, tick, set_pend;
        sel_ch    = 1'b0;
        ctrl_wr   = 1'b0;
        preset_wr = 1'b0;
        stat_clr  = 1'b0;
        tick      = 1'b0;
        set_pend  = 1'b0;
        en_d      = en_q;
        im_d      = im_q;
        pend_d    = pend_q;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            mode_d[i]   = mode_q[i];
            preset_d[i] = preset_q[i];
            count_d[i]  = count_q[i];
`ifdef TIMER_PRESCALE_EN
            psc_d[i]    = psc_q[i];
            pcnt_d[i]   = pcnt_q[i];
`endif
        end

        for (int i = 0; i < N_CH; i++) begin
            sel_ch    = w_wr && (int'(w_ch) == i);
            ctrl_wr   = sel_ch && (w_reg == REG_CTRL);
            preset_wr = sel_ch && (w_reg == REG_PRESET);
            stat_clr  = sel_ch && (w_reg == 2'd3) && wdata[0];
            set_pend  = 1'b0;
`ifdef TIMER_PRESCALE_EN
            tick = (pcnt_q[i] == psc_q[i]);
`else
            tick = 1'b1;
`endif

            if (ctrl_wr) begin
                en_d[i]   = wdata[0];
                mode_d[i] = wdata[2:1];
                im_d[i]   = wdata[3];
`ifdef TIMER_PRESCALE_EN
                psc_d[i]  = wdata[15:8];
`endif
            end
            if (preset_wr) begin
                preset_d[i] = wdata[CNT_W-1:0];
            end

`ifdef TIMER_PRESCALE_EN
            // Prescaler runs in CNT and DONE; DONE also waits for a tick so
            // that every step (including the final one) costs PSC+1 cycles.
            if (state_q[i] == ST_CNT || state_q[i] == ST_DONE) begin
                pcnt_d[i] = tick ? 8'd0 : pcnt_q[i] + 8'd1;
            end
`endif

            case (state_q[i])
                ST_IDLE: begin
                    if (ctrl_wr && wdata[0]) begin
                        state_d[i] = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_d[i] = preset_q[i];
`ifdef TIMER_PRESCALE_EN
                    pcnt_d[i]  = 8'd0;
`endif
                    state_d[i] = ST_CNT;
                end
                ST_CNT: begin
                    if (tick) begin
                        if (count_q[i] > CNT_W'(1)) begin
                            count_d[i] = count_q[i] - CNT_W'(1);
                        end else begin
                            // 1 steps to 0; 0 stays 0 (saturating)
                            count_d[i] = '0;
                            state_d[i] = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (tick) begin
                        set_pend = 1'b1;
                        if (mode_q[i] == MODE_AUTO) begin
                            state_d[i] = ST_LOAD;
                        end else begin
                            en_d[i]    = 1'b0;
                            state_d[i] = ST_IDLE;
                        end
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase

            // Disabling a running channel freezes COUNT and drops any
            // completion that would otherwise land on this edge.
            if (ctrl_wr && !wdata[0] && state_q[i] != ST_IDLE) begin
                state_d[i] = ST_IDLE;
                count_d[i] = count_q[i];
                set_pend   = 1'b0;
            end

            // A completing count beats a simultaneous W1C.
            pend_d[i] = (pend_q[i] & ~stat_clr) | set_pend;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                mode_q[i]   <= '0;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
`ifdef TIMER_PRESCALE_EN
                psc_q[i]    <= '0;
                pcnt_q[i]   <= '0;
`endif
            end
        end else begin
            en_q   <= en_d;
            im_q   <= im_d;
            pend_q <= pend_d;
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                mode_q[i]   <= mode_d[i];
                preset_q[i] <= preset_d[i];
                count_q[i]  <= count_d[i];
`ifdef TIMER_PRESCALE_EN
                psc_q[i]    <= psc_d[i];
                pcnt_q[i]   <= pcnt_d[i];
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_hit && int'(w_ch) == i) begin
                case (w_reg)
                    REG_CTRL: begin
                        rdata[0]   = en_q[i];
                        rdata[2:1] = mode_q[i];
                        rdata[3]   = im_q[i];
`ifdef TIMER_PRESCALE_EN
                        rdata[15:8] = psc_q[i];
`endif
                    end
                    REG_PRESET: rdata[CNT_W-1:0] = preset_q[i];
                    REG_COUNT:  rdata[CNT_W-1:0] = count_q[i];
                    default:    rdata[0]         = pend_q[i];
                endcase
            end
        end
    end

endmodule
`default_nettype wire
